// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: registers a load/store from the MEM stage,
// holds it until MemReady, stalls the pipeline meanwhile and aborts on timeout.
module dmem_req_ctrl #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] write_data_m,
  output logic        memwrite,
  output logic        MemtoRegM,
  output logic [31:0] dataadr,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        MemReady,
  output logic        stall_m,
  output logic [31:0] read_data_m,
  output logic        mem_err,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tmo_cnt;
  logic        req;
  logic        tmo_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req     = mem_read_m | mem_write_m;
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion takes priority over a timeout reached in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (MemReady)     state_nxt = S_DONE;
        else if (tmo_hit) state_nxt = S_ABORT;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_m = 1'b0;
    unique case (state)
      S_IDLE:  stall_m = req;
      S_WAIT:  stall_m = 1'b1;
      default: stall_m = 1'b0;
    endcase
  end

  // Request registers are held untouched for the whole WAIT phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      memwrite    <= 1'b0;
      MemtoRegM   <= 1'b0;
      dataadr     <= 32'd0;
      writedata   <= 32'd0;
      read_data_m <= 32'd0;
      mem_err     <= 1'b0;
      tmo_cnt     <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            dataadr   <= alu_out_m;
            writedata <= write_data_m;
            memwrite  <= mem_write_m;
            MemtoRegM <= mem_read_m & ~mem_write_m;
            tmo_cnt   <= 32'd0;
            if (mem_read_m && mem_write_m) mem_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (MemReady) begin
            if (MemtoRegM) read_data_m <= readdata;
            memwrite  <= 1'b0;
            MemtoRegM <= 1'b0;
          end else if (tmo_hit) begin
            read_data_m <= ERR_DATA;
            mem_err     <= 1'b1;
            memwrite    <= 1'b0;
            MemtoRegM   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= 32'd0;
    end else if (stall_m) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: a default-timeout instance and a
// TIMEOUT=4 instance, each driven with hand-computed vectors.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset, mem_read_m, mem_write_m, MemReady;
  logic [31:0] alu_out_m, write_data_m, readdata;
  logic        memwrite, MemtoRegM, stall_m, mem_err;
  logic [31:0] dataadr, writedata, read_data_m, stall_count;

  logic        t_reset, t_rd, t_wr, t_ready;
  logic [31:0] t_adr, t_wd, t_rdata;
  logic        t_memwrite, t_memtoreg, t_stall, t_err;
  logic [31:0] t_dataadr, t_writedata, t_rdm, t_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_req_ctrl dut (
    .clk(clk), .reset(reset), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .memwrite(memwrite),
    .MemtoRegM(MemtoRegM), .dataadr(dataadr), .writedata(writedata),
    .readdata(readdata), .MemReady(MemReady), .stall_m(stall_m),
    .read_data_m(read_data_m), .mem_err(mem_err), .stall_count(stall_count)
  );

  dmem_req_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(t_reset), .mem_read_m(t_rd), .mem_write_m(t_wr),
    .alu_out_m(t_adr), .write_data_m(t_wd), .memwrite(t_memwrite),
    .MemtoRegM(t_memtoreg), .dataadr(t_dataadr), .writedata(t_writedata),
    .readdata(t_rdata), .MemReady(t_ready), .stall_m(t_stall),
    .read_data_m(t_rdm), .mem_err(t_err), .stall_count(t_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; MemReady = 1'b0;
    alu_out_m = '0; write_data_m = '0; readdata = '0;
    t_reset = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_ready = 1'b0;
    t_adr = '0; t_wd = '0; t_rdata = '0;
    step(); step();
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_memtoreg", {31'd0, MemtoRegM}, 32'd0);
    chk("rst_dataadr", dataadr, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_rdata", read_data_m, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    chk("rst_stall", {31'd0, stall_m}, 32'd0);
    reset = 1'b1; t_reset = 1'b1;

    // single load, ready in first WAIT cycle
    mem_read_m = 1'b1; alu_out_m = 32'h0000_0100;
    #1 chk("ld_idle_stall", {31'd0, stall_m}, 32'd1);
    step();
    chk("ld_wait_rd", {31'd0, MemtoRegM}, 32'd1);
    chk("ld_wait_wr", {31'd0, memwrite}, 32'd0);
    chk("ld_wait_adr", dataadr, 32'h0000_0100);
    chk("ld_wait_stall", {31'd0, stall_m}, 32'd1);
    MemReady = 1'b1; readdata = 32'h1234_5678;
    step();
    chk("ld_done_rd", {31'd0, MemtoRegM}, 32'd0);
    chk("ld_done_data", read_data_m, 32'h1234_5678);
    chk("ld_done_stall", {31'd0, stall_m}, 32'd0);
    chk("ld_done_cnt", stall_count, 32'd2);
    MemReady = 1'b0; readdata = '0; mem_read_m = 1'b0;
    step();
    chk("ld_idle_data", read_data_m, 32'h1234_5678);
    chk("ld_idle_cnt", stall_count, 32'd2);

    // store with MemReady in WAIT cycle 5
    reset = 1'b0; step(); reset = 1'b1;
    mem_write_m = 1'b1; alu_out_m = 32'h0000_0040; write_data_m = 32'hCAFE_F00D;
    step();
    alu_out_m = 32'hFFFF_0000; write_data_m = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("st_w%0d_wr", k), {31'd0, memwrite}, 32'd1);
      chk($sformatf("st_w%0d_adr", k), dataadr, 32'h0000_0040);
      chk($sformatf("st_w%0d_wd", k), writedata, 32'hCAFE_F00D);
      chk($sformatf("st_w%0d_stall", k), {31'd0, stall_m}, 32'd1);
      if (k == 5) MemReady = 1'b1;
      step();
    end
    chk("st_done_wr", {31'd0, memwrite}, 32'd0);
    chk("st_done_cnt", stall_count, 32'd6);
    chk("st_done_stall", {31'd0, stall_m}, 32'd0);
    chk("st_done_rdata", read_data_m, 32'd0);
    MemReady = 1'b0; mem_write_m = 1'b0;
    step();

    // reset in the middle of a load
    mem_read_m = 1'b1; alu_out_m = 32'h0000_0200;
    step();
    chk("rw_wait_rd", {31'd0, MemtoRegM}, 32'd1);
    reset = 1'b0; mem_read_m = 1'b0;
    step();
    chk("rw_rd", {31'd0, MemtoRegM}, 32'd0);
    chk("rw_cnt", stall_count, 32'd0);
    chk("rw_adr", dataadr, 32'd0);
    chk("rw_stall", {31'd0, stall_m}, 32'd0);
    reset = 1'b1; MemReady = 1'b1; readdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stray%0d_rd", k), {31'd0, MemtoRegM}, 32'd0);
      chk($sformatf("stray%0d_wr", k), {31'd0, memwrite}, 32'd0);
      chk($sformatf("stray%0d_rdata", k), read_data_m, 32'd0);
      chk($sformatf("stray%0d_err", k), {31'd0, mem_err}, 32'd0);
      chk($sformatf("stray%0d_cnt", k), stall_count, 32'd0);
    end
    MemReady = 1'b0;
    mem_read_m = 1'b1; alu_out_m = 32'h0000_0204;
    step();
    chk("rl_wait_rd", {31'd0, MemtoRegM}, 32'd1);
    chk("rl_wait_adr", dataadr, 32'h0000_0204);
    MemReady = 1'b1; readdata = 32'h0A0B_0C0D;
    step();
    chk("rl_done_data", read_data_m, 32'h0A0B_0C0D);
    chk("rl_done_cnt", stall_count, 32'd2);
    mem_read_m = 1'b0; MemReady = 1'b0;
    step();

    // both request inputs set: issued as a store with error
    mem_read_m = 1'b1; mem_write_m = 1'b1;
    alu_out_m = 32'h0000_0300; write_data_m = 32'h55AA_55AA;
    step();
    chk("both_wr", {31'd0, memwrite}, 32'd1);
    chk("both_rd", {31'd0, MemtoRegM}, 32'd0);
    chk("both_err", {31'd0, mem_err}, 32'd1);
    chk("both_wd", writedata, 32'h55AA_55AA);
    MemReady = 1'b1; readdata = 32'hFFFF_FFFF;
    step();
    chk("both_done_wr", {31'd0, memwrite}, 32'd0);
    chk("both_done_rdata", read_data_m, 32'h0A0B_0C0D);
    mem_read_m = 1'b0; mem_write_m = 1'b0; MemReady = 1'b0;
    step();

    // TIMEOUT=4: MemReady in the last allowed WAIT cycle completes
    t_rd = 1'b1; t_adr = 32'h0000_0080;
    step();
    chk("edge_w1_rd", {31'd0, t_memtoreg}, 32'd1);
    step(); step(); step();
    chk("edge_w4_rd", {31'd0, t_memtoreg}, 32'd1);
    t_ready = 1'b1; t_rdata = 32'h1357_2468;
    step();
    chk("edge_done_data", t_rdm, 32'h1357_2468);
    chk("edge_done_err", {31'd0, t_err}, 32'd0);
    chk("edge_done_rd", {31'd0, t_memtoreg}, 32'd0);
    t_rd = 1'b0; t_ready = 1'b0;
    step();

    // TIMEOUT=4: no MemReady, abort after 4 WAIT cycles
    t_rd = 1'b1; t_adr = 32'h0000_0084;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_w%0d_rd", k), {31'd0, t_memtoreg}, 32'd1);
      step();
    end
    chk("to_abort_rd", {31'd0, t_memtoreg}, 32'd0);
    chk("to_abort_data", t_rdm, 32'hDEAD_BEEF);
    chk("to_abort_err", {31'd0, t_err}, 32'd1);
    chk("to_abort_stall", {31'd0, t_stall}, 32'd0);
    chk("to_abort_cnt", t_cnt, 32'd10);
    t_rd = 1'b0;
    step();
    t_rd = 1'b1; t_adr = 32'h0000_0088;
    step();
    t_ready = 1'b1; t_rdata = 32'h2468_ACE0;
    step();
    chk("to_good_data", t_rdm, 32'h2468_ACE0);
    chk("to_good_err", {31'd0, t_err}, 32'd1);
    t_rd = 1'b0; t_ready = 1'b0;
    step();
    chk("to_idle_err", {31'd0, t_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
# dmem_req_ctrl

CPU-side initiator for the data-memory ready/valid handshake. It sits between the MIPS memory stage and the data memory. It registers each load or store request and holds it stable until the memory raises `MemReady`, stalling the pipeline meanwhile. It returns captured load data and aborts any access that exceeds a configurable timeout.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort; 0 disables the timeout.
- `ERR_DATA`, default 32'hDEADBEEF: value returned as load data on abort.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `mem_read_m` in 1: memory stage holds a load.
- `mem_write_m` in 1: memory stage holds a store.
- `alu_out_m` in 32: byte address from the memory stage.
- `write_data_m` in 32: store data from the memory stage.
- `memwrite` out 1: write request to data memory (registered).
- `MemtoRegM` out 1: read request to data memory (registered).
- `dataadr` out 32: request address (registered).
- `writedata` out 32: store data (registered).
- `readdata` in 32: load data from memory; valid when `MemReady`=1.
- `MemReady` in 1: memory completion; sampled only in WAIT.
- `stall_m` out 1: freeze IF through MEM stages.
- `read_data_m` out 32: captured load data; valid in DONE.
- `mem_err` out 1: sticky error flag.
- `stall_count` out 32: saturating count of cycles with `stall_m`=1.

## Operation
- States: IDLE, WAIT, DONE, ABORT.
- Reset (`reset`=0 at an edge), from any state including mid-transaction:
  - State goes to IDLE.
  - `memwrite`, `MemtoRegM`, `mem_err` and `stall_count` go to 0.
  - `dataadr`, `writedata` and `read_data_m` go to 0.
  - Request outputs drop on that same edge; an in-flight memory response is ignored.
- IDLE:
  - `stall_m` = `mem_read_m | mem_write_m` (combinational).
  - On a request, the edge latches `alu_out_m` into `dataadr` and `write_data_m` into `writedata`.
  - The same edge sets `memwrite` (store) or `MemtoRegM` (load), clears the timeout counter and enters WAIT.
  - If both request inputs are 1, the access is a store and `mem_err` is set.
- WAIT:
  - `stall_m`=1; request outputs are held bit-stable.
  - `MemReady`=1: the edge captures `readdata` into `read_data_m` (loads only; stores leave it unchanged), clears both request outputs and enters DONE.
  - `MemReady`=0 with counter = `TIMEOUT`-1 (and `TIMEOUT`≠0): the edge clears the requests, sets `read_data_m` = `ERR_DATA`, sets `mem_err` and enters ABORT.
  - Otherwise the counter increments.
  - If `MemReady` arrives in the same cycle the timeout is reached, completion wins.
- DONE:
  - `stall_m`=0, so the pipeline advances on this edge.
  - The request inputs still describe the finished access and are ignored.
  - Next state is always IDLE.
- ABORT: same as DONE (`stall_m`=0, inputs ignored, next state IDLE); `mem_err` stays set.
- `MemReady` in IDLE, DONE or ABORT is ignored and sets no error.
- `stall_count` increments on every edge where `stall_m`=1 and saturates at 32'hFFFFFFFF.
- `mem_err` clears only on reset.

## Timing
- Minimum access (`MemReady` in the first WAIT cycle) takes 3 cycles: IDLE (`stall_m`=1), WAIT (`stall_m`=1), DONE (`stall_m`=0). That is 2 stall cycles.
- With `MemReady` in WAIT cycle k (k≥1), `stall_m` is high for k+1 cycles.
- A WAIT lasts at most `TIMEOUT` cycles. A timed-out access stalls `TIMEOUT`+1 cycles.
- `memwrite` and `MemtoRegM` are high exactly during WAIT.
- Back-to-back accesses have a 1-cycle gap (DONE) with no request asserted.
- `read_data_m` is stable from DONE until the next capture.

## Test plan
- Single load, memory returns 32'h12345678 with `MemReady` in WAIT cycle 1:
  - `MemtoRegM` high for 1 cycle with `dataadr` = load address.
  - `stall_m` high for 2 cycles.
  - `read_data_m` = 32'h12345678 in DONE.
- Store of 32'hCAFEF00D to 0x40, `MemReady` delayed 5 cycles:
  - `memwrite`, `dataadr` = 0x40 and `writedata` held stable for all 5 WAIT cycles.
  - `stall_m` high for 6 cycles.
  - `stall_count` = 6.
- `TIMEOUT`=4, `MemReady` never asserted:
  - ABORT after 4 WAIT cycles.
  - `read_data_m` = 32'hDEADBEEF; `mem_err`=1 and remains 1 through a following good load.
- `MemReady` first asserted in the cycle the counter reaches `TIMEOUT`-1: the access completes normally and `mem_err` stays 0.
- Reset driven low during WAIT of a load:
  - Next edge: IDLE, `MemtoRegM`=0 and `stall_count`=0.
  - A late `MemReady` is ignored.
  - A subsequent load completes correctly.
- `mem_read_m` and `mem_write_m` both 1: the access is issued as a store (`memwrite`=1, `MemtoRegM`=0) and `mem_err`=1. Stray `MemReady` pulses in IDLE cause no state change.
